// File: rtl/gate_monitor.sv
// Gate-pair monitor. It recovers the switching signal from a complementary
// gate pair, measures the dead band of every completed transition, and
// latches a fault on shoot-through, a missing dead band or an over-long one.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no stable level seen yet (after reset or fault clear)
// S_HI    | stable g=01, sp_rec=1
// S_LO    | stable g=10, sp_rec=0
// S_DEAD  | inside a dead band (g=00), cnt = number of 00 samples so far
// S_FAULT | fault latched, waiting for clr_fault with g != 11
module gate_monitor #(
  parameter int CW     = 8,
  parameter int MIN_DT = 1,
  parameter int MAX_DT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    g,
  input  logic          clr_fault,
  output logic          sp_rec,
  output logic [CW-1:0] dt_cnt,
  output logic          dt_valid,
  output logic          fault,
  output logic [1:0]    fault_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_DEAD,
    S_FAULT
  } state_t;

  localparam logic [1:0] G_DEAD = 2'b00;
  localparam logic [1:0] G_HI   = 2'b01;
  localparam logic [1:0] G_LO   = 2'b10;
  localparam logic [1:0] G_ST   = 2'b11;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_SHOOT = 2'b01;
  localparam logic [1:0] FC_SHORT = 2'b10;
  localparam logic [1:0] FC_LONG  = 2'b11;

  localparam logic [CW-1:0] MIN_C = CW'(MIN_DT);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_DT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        state;
  logic          origin_hi;
  logic [CW-1:0] cnt;

  // Single registered FSM: every output is written on the edge that samples g.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      origin_hi  <= 1'b0;
      cnt        <= '0;
      sp_rec     <= 1'b0;
      dt_cnt     <= '0;
      dt_valid   <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      dt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          case (g)
            G_HI: begin
              state  <= S_HI;
              sp_rec <= 1'b1;
            end
            G_LO: begin
              state  <= S_LO;
              sp_rec <= 1'b0;
            end
            G_ST: begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_SHOOT;
            end
            default: ;
          endcase
        end

        S_HI, S_LO: begin
          if (g == G_ST) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_SHOOT;
          end else if (g == G_DEAD) begin
            state     <= S_DEAD;
            cnt       <= ONE_C;
            origin_hi <= (state == S_HI);
          end else if ((g == G_LO) == (state == S_HI)) begin
            // direct swap with no dead band at all
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_SHORT;
          end
        end

        S_DEAD: begin
          if (g == G_ST) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_SHOOT;
          end else if (g == G_DEAD) begin
            // cnt tops out at MAX_DT, so it can never wrap
            if (cnt >= MAX_C) begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_LONG;
            end else begin
              cnt <= cnt + ONE_C;
            end
          end else if ((g == G_HI) == origin_hi) begin
            // aborted transition: back to where we came from, nothing reported
            state <= origin_hi ? S_HI : S_LO;
          end else if (cnt < MIN_C) begin
            state      <= S_FAULT;
            fault      <= 1'b1;
            fault_code <= FC_SHORT;
          end else begin
            state    <= origin_hi ? S_LO : S_HI;
            sp_rec   <= ~origin_hi;
            dt_cnt   <= cnt;
            dt_valid <= 1'b1;
          end
        end

        S_FAULT: begin
          if (clr_fault && (g != G_ST)) begin
            state      <= S_IDLE;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
